// File: rtl/output_interface_pkg.sv
// Shared constants, op encodings, flag indices and FSM states for the FPU output packer.
package output_interface_pkg;
  localparam int MANT_W   = 56;
  localparam int EXP_W    = 13;
  localparam int REG_SIZE = 64;
  localparam int OP_BITS  = 2;

  localparam logic [OP_BITS-1:0] OP_SINGLE = 2'b00;
  localparam logic [OP_BITS-1:0] OP_DOUBLE = 2'b10;

  localparam int FLAG_NAN  = 2;
  localparam int FLAG_INF  = 1;
  localparam int FLAG_ZERO = 0;

  localparam logic signed [EXP_W-1:0] EXP_ONE = 13'sd1;
  localparam logic signed [EXP_W-1:0] EMAX_SP = 13'sd255;
  localparam logic signed [EXP_W-1:0] EMAX_DP = 13'sd2047;

  localparam logic [31:0] QNAN_SP = 32'h7FC0_0000;
  localparam logic [63:0] QNAN_DP = 64'h7FF8_0000_0000_0000;

  typedef enum logic [2:0] {ST_IDLE, ST_NORM, ST_ROUND, ST_PACK, ST_OUT} state_e;

  // Guard/sticky OR for the selected precision: nonzero means the result is inexact.
  function automatic logic lost_bits(input logic [MANT_W-1:0] m, input logic dbl);
    return dbl ? (m[1] | m[0]) : (m[30] | (|m[29:0]));
  endfunction
endpackage

// File: rtl/output_packer.sv
// Combinational encoder: special cases, overflow to Inf, denormal and normal field assembly.
module output_packer
  import output_interface_pkg::*;
(
  input  logic [MANT_W-1:0]   mant_i,
  input  logic [EXP_W-1:0]    exp_i,
  input  logic                sign_i,
  input  logic [2:0]          flags_i,
  input  logic                dbl_i,
  input  logic                inexact_i,
  output logic [REG_SIZE-1:0] result_o,
  output logic                ovf_o,
  output logic                unf_o,
  output logic                inexact_o
);
  logic signed [EXP_W-1:0] exp_s;
  logic signed [EXP_W-1:0] emax;
  logic [REG_SIZE-1:0]     inf_word;

  assign exp_s    = exp_i;
  assign emax     = dbl_i ? EMAX_DP : EMAX_SP;
  assign inf_word = dbl_i ? {sign_i, 11'h7FF, 52'h0} : {32'h0, sign_i, 8'hFF, 23'h0};

  always_comb begin
    result_o  = '0;
    ovf_o     = 1'b0;
    unf_o     = 1'b0;
    inexact_o = 1'b0;
    if (flags_i[FLAG_NAN]) begin
      result_o = dbl_i ? {sign_i, QNAN_DP[62:0]} : {32'h0, sign_i, QNAN_SP[30:0]};
    end else if (flags_i[FLAG_INF]) begin
      result_o = inf_word;
    end else if (flags_i[FLAG_ZERO] || mant_i == '0) begin
      result_o = dbl_i ? {sign_i, 63'h0} : {32'h0, sign_i, 31'h0};
    end else if (exp_s >= emax) begin
      result_o  = inf_word;
      ovf_o     = 1'b1;
      inexact_o = 1'b1;
    end else if (exp_s == EXP_ONE && !mant_i[54]) begin
      // Denormal: exponent field is zero, fraction keeps its leading zeros.
      result_o  = dbl_i ? {sign_i, 11'h0, mant_i[53:2]} : {32'h0, sign_i, 8'h0, mant_i[53:31]};
      unf_o     = inexact_i;
      inexact_o = inexact_i;
    end else begin
      result_o  = dbl_i ? {sign_i, exp_i[10:0], mant_i[53:2]}
                        : {32'h0, sign_i, exp_i[7:0], mant_i[53:31]};
      inexact_o = inexact_i;
    end
  end
endmodule

// File: rtl/output_interface.sv
// FPU output interface: normalizes, rounds and packs unpacked operands into IEEE-754 words.
// OUTPUT_INTERFACE_ROUND_EN enables the ROUND state (nearest-even); otherwise results truncate.
module output_interface
  import output_interface_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MANT_W-1:0]   mant,
  input  logic [EXP_W-1:0]    exp,
  input  logic                sign,
  input  logic [2:0]          flags,
  input  logic [OP_BITS-1:0]  op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [REG_SIZE-1:0] result,
  output logic                ovf,
  output logic                unf,
  output logic                inexact
);
  state_e                  state_q, state_d;
  logic [MANT_W-1:0]       mant_q, mant_d;
  logic signed [EXP_W-1:0] exp_q, exp_d;
  logic                    sign_q, sign_d;
  logic [2:0]              flags_q, flags_d;
  logic                    dbl_q, dbl_d;
  logic                    lost_q, lost_d;
  logic [REG_SIZE-1:0]     result_q, result_d;
  logic                    ovf_q, ovf_d, unf_q, unf_d, inx_q, inx_d;

  logic [REG_SIZE-1:0]     pk_result;
  logic                    pk_ovf, pk_unf, pk_inexact;

  function automatic logic [MANT_W-1:0] shr1(input logic [MANT_W-1:0] m);
    return {1'b0, m[MANT_W-1:2], m[1] | m[0]};
  endfunction

`ifdef OUTPUT_INTERFACE_ROUND_EN
  localparam logic [MANT_W-1:0] ULP_SP = 56'h00_0000_8000_0000;
  localparam logic [MANT_W-1:0] ULP_DP = 56'h00_0000_0000_0004;

  function automatic logic [MANT_W-1:0] rne(input logic [MANT_W-1:0] m, input logic dbl);
    logic lsb, grd, stk;
    lsb = dbl ? m[2] : m[31];
    grd = dbl ? m[1] : m[30];
    stk = dbl ? m[0] : (|m[29:0]);
    return (grd && (stk || lsb)) ? m + (dbl ? ULP_DP : ULP_SP) : m;
  endfunction

  logic [MANT_W-1:0] rnd;
  assign rnd = rne(mant_q, dbl_q);
`endif

  always_comb begin
    state_d  = state_q;
    mant_d   = mant_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    flags_d  = flags_q;
    dbl_d    = dbl_q;
    lost_d   = lost_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    inx_d    = inx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mant_d  = mant;
          exp_d   = exp;
          sign_d  = sign;
          flags_d = flags;
          dbl_d   = (op == OP_DOUBLE);
          lost_d  = 1'b0;
          state_d = ((|flags) || mant == '0) ? ST_PACK : ST_NORM;
        end
      end
      ST_NORM: begin
        if (mant_q[MANT_W-1] || exp_q < EXP_ONE) begin
          mant_d = shr1(mant_q);
          exp_d  = exp_q + EXP_ONE;
        end else if (!mant_q[54] && exp_q > EXP_ONE) begin
          mant_d = {mant_q[MANT_W-2:0], 1'b0};
          exp_d  = exp_q - EXP_ONE;
        end else begin
`ifdef OUTPUT_INTERFACE_ROUND_EN
          state_d = ST_ROUND;
`else
          lost_d  = lost_bits(mant_q, dbl_q);
          state_d = ST_PACK;
`endif
        end
      end
`ifdef OUTPUT_INTERFACE_ROUND_EN
      ST_ROUND: begin
        lost_d = lost_bits(mant_q, dbl_q);
        if (rnd[MANT_W-1]) begin
          mant_d = shr1(rnd);
          exp_d  = exp_q + EXP_ONE;
        end else begin
          mant_d = rnd;
        end
        state_d = ST_PACK;
      end
`endif
      ST_PACK: begin
        result_d = pk_result;
        ovf_d    = pk_ovf;
        unf_d    = pk_unf;
        inx_d    = pk_inexact;
        state_d  = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  output_packer u_packer (
    .mant_i    (mant_q),
    .exp_i     (exp_q),
    .sign_i    (sign_q),
    .flags_i   (flags_q),
    .dbl_i     (dbl_q),
    .inexact_i (lost_q),
    .result_o  (pk_result),
    .ovf_o     (pk_ovf),
    .unf_o     (pk_unf),
    .inexact_o (pk_inexact)
  );

  // Control and visible outputs are reset; operand working registers are not.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      inx_q    <= inx_d;
    end
  end

  always_ff @(posedge clk) begin
    mant_q  <= mant_d;
    exp_q   <= exp_d;
    sign_q  <= sign_d;
    flags_q <= flags_d;
    dbl_q   <= dbl_d;
    lost_q  <= lost_d;
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_OUT);
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;
  assign inexact   = inx_q;
endmodule

// File: tb/tb_output_interface.sv
// Scoreboard bench for output_interface; expectations follow OUTPUT_INTERFACE_ROUND_EN.
module tb_output_interface;
`ifdef OUTPUT_INTERFACE_ROUND_EN
  localparam int RL = 1;
  localparam logic [63:0] ODD_TIE  = 64'h3F80_0002;
  localparam logic [63:0] DP_CARRY = 64'h4000_0000_0000_0000;
`else
  localparam int RL = 0;
  localparam logic [63:0] ODD_TIE  = 64'h3F80_0001;
  localparam logic [63:0] DP_CARRY = 64'h3FFF_FFFF_FFFF_FFFF;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [55:0] mant_v = '0;
  logic [12:0] exp_v = '0;
  logic        sign_v = 1'b0;
  logic [2:0]  flags_v = '0;
  logic [1:0]  op_v = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;
  logic        ovf, unf, inexact;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [63:0] res;
    logic [2:0]  fl;
    int          lat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [55:0] m;
    logic [12:0] e;
    logic        s;
    logic [2:0]  f;
    logic [1:0]  o;
  } stim_t;

  output_interface dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mant      (mant_v),
    .exp       (exp_v),
    .sign      (sign_v),
    .flags     (flags_v),
    .op        (op_v),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf),
    .unf       (unf),
    .inexact   (inexact)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one operand; returns output seen at the first negedge with out_valid, and its cycle number.
  task automatic run_op(input stim_t st, output logic [63:0] r, output logic [2:0] fl, output int lat);
    @(negedge clk);
    mant_v = st.m; exp_v = st.e; sign_v = st.s; flags_v = st.f; op_v = st.o;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    r  = result;
    fl = {ovf, unf, inexact};
  endtask

  task automatic ack_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid); else passed++;
    total++; if (result !== 64'h0) $display("FAIL reset_result got=%h want=0", result); else passed++;
    total++; if ({ovf, unf, inexact} !== 3'b000) $display("FAIL reset_flags got=%b want=000", {ovf, unf, inexact}); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_normal();
    stim_t st[6];
    logic [63:0] r; logic [2:0] fl; int lat; exp_t e;
    st[0] = '{56'h40_0000_0000_0000, 13'd127, 1'b0, 3'b000, 2'b00};  sb.push_back('{64'h3F80_0000, 3'b000, 4 + RL - 1 + 1 - 1 + 0});
    st[1] = '{56'h04_0000_0000_0000, 13'd1027, 1'b0, 3'b000, 2'b10}; sb.push_back('{64'h3FF0_0000_0000_0000, 3'b000, 7 + RL});
    st[2] = '{56'h80_0000_0000_0000, 13'd127, 1'b1, 3'b000, 2'b00};  sb.push_back('{64'hC000_0000, 3'b000, 4 + RL});
    st[3] = '{56'h40_0000_0000_0000, 13'd255, 1'b0, 3'b000, 2'b00};  sb.push_back('{64'h7F80_0000, 3'b101, 3 + RL});
    st[4] = '{56'h40_0000_0000_0000, 13'h1FFF, 1'b0, 3'b000, 2'b00}; sb.push_back('{64'h0020_0000, 3'b000, 5 + RL});
    st[5] = '{56'h40_0000_8000_0000, 13'd0, 1'b0, 3'b000, 2'b00};    sb.push_back('{64'h0040_0000, 3'b011, 4 + RL});
    for (int i = 0; i < 6; i++) begin
      run_op(st[i], r, fl, lat);
      e = sb.pop_front();
      total++; if (r !== e.res) $display("FAIL normal[%0d]_result got=%h want=%h", i, r, e.res); else passed++;
      total++; if (fl !== e.fl) $display("FAIL normal[%0d]_flags got=%b want=%b", i, fl, e.fl); else passed++;
      total++; if (lat !== e.lat) $display("FAIL normal[%0d]_latency got=%0d want=%0d", i, lat, e.lat); else passed++;
      total++; if (in_ready !== 1'b0) $display("FAIL normal[%0d]_in_ready_busy got=%b want=0", i, in_ready); else passed++;
      ack_out();
    end
  endtask

  task automatic test_rounding();
    stim_t st[3];
    logic [63:0] r; logic [2:0] fl; int lat; exp_t e;
    st[0] = '{56'h40_0000_4000_0000, 13'd127, 1'b0, 3'b000, 2'b00};  sb.push_back('{64'h3F80_0000, 3'b001, 3 + RL});
    st[1] = '{56'h40_0000_C000_0000, 13'd127, 1'b0, 3'b000, 2'b00};  sb.push_back('{ODD_TIE, 3'b001, 3 + RL});
    st[2] = '{56'h7F_FFFF_FFFF_FFFF, 13'd1023, 1'b0, 3'b000, 2'b10}; sb.push_back('{DP_CARRY, 3'b001, 3 + RL});
    for (int i = 0; i < 3; i++) begin
      run_op(st[i], r, fl, lat);
      e = sb.pop_front();
      total++; if (r !== e.res) $display("FAIL round[%0d]_result got=%h want=%h", i, r, e.res); else passed++;
      total++; if (fl !== e.fl) $display("FAIL round[%0d]_flags got=%b want=%b", i, fl, e.fl); else passed++;
      total++; if (lat !== e.lat) $display("FAIL round[%0d]_latency got=%0d want=%0d", i, lat, e.lat); else passed++;
      ack_out();
    end
  endtask

  task automatic test_special_backpressure();
    stim_t st[5];
    logic [63:0] r; logic [2:0] fl; int lat; exp_t e;
    st[0] = '{56'h12_3456_0000_0000, 13'd5, 1'b1, 3'b100, 2'b00};    sb.push_back('{64'hFFC0_0000, 3'b000, 2});
    st[1] = '{56'h40_0000_0000_0000, 13'd3, 1'b0, 3'b100, 2'b10};    sb.push_back('{64'h7FF8_0000_0000_0000, 3'b000, 2});
    st[2] = '{56'h40_0000_0000_0000, 13'd9, 1'b0, 3'b010, 2'b10};    sb.push_back('{64'h7FF0_0000_0000_0000, 3'b000, 2});
    st[3] = '{56'h40_0000_0000_0000, 13'd9, 1'b1, 3'b001, 2'b00};    sb.push_back('{64'h8000_0000, 3'b000, 2});
    st[4] = '{56'h00_0000_0000_0000, 13'd900, 1'b1, 3'b000, 2'b10};  sb.push_back('{64'h8000_0000_0000_0000, 3'b000, 2});
    for (int i = 0; i < 5; i++) begin
      run_op(st[i], r, fl, lat);
      e = sb.pop_front();
      total++; if (r !== e.res) $display("FAIL special[%0d]_result got=%h want=%h", i, r, e.res); else passed++;
      total++; if (fl !== e.fl) $display("FAIL special[%0d]_flags got=%b want=%b", i, fl, e.fl); else passed++;
      total++; if (lat !== e.lat) $display("FAIL special[%0d]_latency got=%0d want=%0d", i, lat, e.lat); else passed++;
      if (i == 0) begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          total++;
          if (result !== e.res || in_ready !== 1'b0 || out_valid !== 1'b1)
            $display("FAIL stall[%0d] got result=%h in_ready=%b out_valid=%b want result=%h in_ready=0 out_valid=1",
                     k, result, in_ready, out_valid, e.res);
          else passed++;
        end
      end
      ack_out();
    end
  endtask

  task automatic test_reset_mid_norm();
    stim_t st;
    logic [63:0] r; logic [2:0] fl; int lat; exp_t e;
    @(negedge clk);
    mant_v = 56'h04_0000_0000_0000; exp_v = 13'd1027; sign_v = 1'b0; flags_v = 3'b000; op_v = 2'b10;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL midreset_out_valid got=%b want=0", out_valid); else passed++;
    total++; if (result !== 64'h0) $display("FAIL midreset_result got=%h want=0", result); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL midreset_in_ready got=%b want=1", in_ready); else passed++;
    st = '{56'h40_0000_0000_0000, 13'd127, 1'b0, 3'b000, 2'b00};
    sb.push_back('{64'h3F80_0000, 3'b000, 3 + RL});
    run_op(st, r, fl, lat);
    e = sb.pop_front();
    total++; if (r !== e.res) $display("FAIL midreset_next_result got=%h want=%h", r, e.res); else passed++;
    total++; if (lat !== e.lat) $display("FAIL midreset_next_latency got=%0d want=%0d", lat, e.lat); else passed++;
    ack_out();
  endtask

  task automatic test_back_to_back();
    stim_t st[6];
    logic [63:0] r; logic [2:0] fl; int lat; exp_t e;
    logic [7:0] ex; logic [22:0] fr; logic s;
    for (int i = 0; i < 6; i++) begin
      ex = 8'($urandom_range(100, 150));
      fr = 23'($urandom);
      s  = 1'($urandom);
      st[i] = '{{1'b0, 1'b1, fr, 31'h0}, {5'h0, ex}, s, 3'b000, 2'b00};
      sb.push_back('{{32'h0, s, ex, fr}, 3'b000, 3 + RL});
    end
    for (int i = 0; i < 6; i++) begin
      run_op(st[i], r, fl, lat);
      e = sb.pop_front();
      total++; if (r !== e.res) $display("FAIL b2b[%0d]_result got=%h want=%h", i, r, e.res); else passed++;
      total++; if (fl !== e.fl) $display("FAIL b2b[%0d]_flags got=%b want=%b", i, fl, e.fl); else passed++;
      ack_out();
      total++; if (in_ready !== 1'b1) $display("FAIL b2b[%0d]_idle_reentry got=%b want=1", i, in_ready); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_rounding();
    test_special_backpressure();
    test_reset_mid_norm();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
